// File: rtl/sa_sched_ctrl.sv
// Job scheduler for a ROWS x COLS weight-stationary systolic array.
// It loads weights from the top edge, feeds skewed activations from the left, and deskews the bottom-edge results.
module sa_sched_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 10,
  parameter int COLS       = 5,
  parameter int KW         = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [KW-1:0]              k_len,
  output logic                       busy,
  output logic                       done,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [COLS*DATA_WIDTH-1:0] w_data,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] a_data,
  output logic [ROWS*COLS-1:0]       sa_mode,
  output logic [COLS-1:0]            sa_en_up,
  output logic [COLS*DATA_WIDTH-1:0] sa_data_up,
  output logic [ROWS-1:0]            sa_en_left,
  output logic [ROWS*DATA_WIDTH-1:0] sa_data_left,
  input  logic [COLS-1:0]            sa_en_down,
  input  logic [COLS*DATA_WIDTH-1:0] sa_data_down,
  output logic                       r_valid,
  output logic [COLS*DATA_WIDTH-1:0] r_data
);
  localparam int DW  = DATA_WIDTH;
  localparam int LCW = $clog2(ROWS + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [LCW-1:0] load_cnt;
  logic [KW-1:0]  k_reg, a_cnt, r_cnt;
  logic           start_ok, w_fire, a_fire, r_count_en;

  assign start_ok   = (state == S_IDLE) && start;
  assign w_fire     = w_valid && w_ready;
  assign a_fire     = a_valid && a_ready;
  assign r_count_en = (state == S_STREAM) || (state == S_DRAIN);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD;
      S_LOAD:   if (w_fire && load_cnt == LCW'(ROWS - 1))
                  state_nxt = (k_reg != '0) ? S_STREAM : S_DONE;
      S_STREAM: if (a_fire && a_cnt == k_reg - KW'(1)) state_nxt = S_DRAIN;
      S_DRAIN:  if (r_cnt == k_reg) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    w_ready    = 1'b0;
    a_ready    = 1'b0;
    sa_mode    = '0;
    sa_en_up   = '0;
    sa_data_up = '0;
    unique case (state)
      S_LOAD: begin
        busy    = 1'b1;
        w_ready = 1'b1;
        sa_mode = '1;
        if (w_valid) begin
          sa_en_up   = '1;
          sa_data_up = w_data;
        end
      end
      S_STREAM: begin
        busy    = 1'b1;
        a_ready = (a_cnt != k_reg);
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Job counters saturate at their limit and restart only on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt <= '0;
      a_cnt    <= '0;
      r_cnt    <= '0;
      k_reg    <= '0;
    end else if (start_ok) begin
      load_cnt <= '0;
      a_cnt    <= '0;
      r_cnt    <= '0;
      k_reg    <= k_len;
    end else begin
      if (w_fire && load_cnt != LCW'(ROWS))    load_cnt <= load_cnt + LCW'(1);
      if (a_fire && a_cnt != k_reg)            a_cnt    <= a_cnt + KW'(1);
      if (r_valid && r_count_en && r_cnt != k_reg) r_cnt <= r_cnt + KW'(1);
    end
  end

  // Left-edge skew: row i is delayed i cycles. Row 0 passes straight through.
  for (genvar i = 0; i < ROWS; i++) begin : g_skew
    logic [DW-1:0] row_in;
    assign row_in = a_fire ? a_data[i*DW +: DW] : '0;
    if (i == 0) begin : g_pass
      assign sa_en_left[i]            = a_fire;
      assign sa_data_left[i*DW +: DW] = row_in;
    end else begin : g_chain
      logic [i-1:0]  en_q;
      logic [DW-1:0] data_q [i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          en_q <= '0;
          // NOTE: the data stages are cleared too, so the outputs read zero right after reset.
          for (int s = 0; s < i; s++) data_q[s] <= '0;
        end else begin
          en_q[0]   <= a_fire;
          data_q[0] <= row_in;
          for (int s = 1; s < i; s++) begin
            en_q[s]   <= en_q[s-1];
            data_q[s] <= data_q[s-1];
          end
        end
      end
      assign sa_en_left[i]            = en_q[i-1];
      assign sa_data_left[i*DW +: DW] = data_q[i-1];
    end
  end

  // Output deskew: column j waits COLS-1-j cycles, so a result row lines up with the last column.
  for (genvar j = 0; j < COLS; j++) begin : g_deskew
    localparam int D = COLS - 1 - j;
    logic [DW-1:0] col_in;
    assign col_in = sa_en_down[j] ? sa_data_down[j*DW +: DW] : '0;
    if (D == 0) begin : g_pass
      assign r_data[j*DW +: DW] = col_in;
    end else begin : g_chain
      logic [DW-1:0] data_q [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < D; s++) data_q[s] <= '0;
        end else begin
          data_q[0] <= col_in;
          for (int s = 1; s < D; s++) data_q[s] <= data_q[s-1];
        end
      end
      assign r_data[j*DW +: DW] = data_q[D-1];
    end
  end

  assign r_valid = sa_en_down[COLS-1];

endmodule

// File: tb/tb_sa_sched_ctrl.sv
// Self-checking bench for sa_sched_ctrl: directed job scenarios plus random jobs.
// Outputs are checked every cycle against a time-scheduled reference model.
`timescale 1ns/1ps
module tb_sa_sched_ctrl;
  localparam int DW = 32, ROWS = 10, COLS = 5, KW = 8, RING = 64;

  logic                 clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [KW-1:0]        k_len = '0;
  logic                 busy, done, w_ready, a_ready, r_valid;
  logic                 w_valid = 1'b0, a_valid = 1'b0;
  logic [COLS*DW-1:0]   w_data = '0, sa_data_up, sa_data_down = '0, r_data;
  logic [ROWS*DW-1:0]   a_data = '0, sa_data_left;
  logic [ROWS*COLS-1:0] sa_mode;
  logic [COLS-1:0]      sa_en_up, sa_en_down = '0;
  logic [ROWS-1:0]      sa_en_left;

  always #5 clk = ~clk;

  sa_sched_ctrl #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .sa_mode(sa_mode), .sa_en_up(sa_en_up), .sa_data_up(sa_data_up),
    .sa_en_left(sa_en_left), .sa_data_left(sa_data_left),
    .sa_en_down(sa_en_down), .sa_data_down(sa_data_down),
    .r_valid(r_valid), .r_data(r_data)
  );

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a job phase and event counts, plus per-cycle schedules of expected edge traffic.
  typedef enum {P_IDLE, P_LOAD, P_STREAM, P_DRAIN, P_DONE} phase_e;
  phase_e ph = P_IDLE;
  int m_rows = 0, m_acc = 0, m_res = 0, m_k = 0, cyc = 0;
  logic [ROWS-1:0]    exp_left_en [RING];
  logic [DW-1:0]      exp_left_d  [RING][ROWS];
  logic               exp_r       [RING];
  logic [COLS*DW-1:0] exp_rd      [RING];
  logic [COLS-1:0]    drv_en      [RING];
  logic [DW-1:0]      drv_d       [RING][COLS];
  int obs_done, obs_rv, obs_acc, obs_up, obs_ar, rv_at_done;

  task automatic clear_model();
    ph = P_IDLE; m_rows = 0; m_acc = 0; m_res = 0; m_k = 0;
    for (int t = 0; t < RING; t++) begin
      exp_left_en[t] = '0; exp_r[t] = 1'b0; exp_rd[t] = '0; drv_en[t] = '0;
      for (int i = 0; i < ROWS; i++) exp_left_d[t][i] = '0;
      for (int j = 0; j < COLS; j++) drv_d[t][j] = '0;
    end
  endtask

  // The array model: one result row arrives column-skewed, column j at cycle t0+j.
  task automatic sched_result(input int t0, input logic [COLS*DW-1:0] row);
    for (int j = 0; j < COLS; j++) begin
      drv_en[(t0+j)%RING][j] = 1'b1;
      drv_d[(t0+j)%RING][j]  = row[j*DW +: DW];
    end
    exp_r[(t0+COLS-1)%RING]  = 1'b1;
    exp_rd[(t0+COLS-1)%RING] = row;
  endtask

  function automatic logic [COLS*DW-1:0] rand_row();
    logic [COLS*DW-1:0] v;
    for (int j = 0; j < COLS; j++) v[j*DW +: DW] = $urandom;
    return v;
  endfunction

  function automatic logic [ROWS*DW-1:0] rand_vec();
    logic [ROWS*DW-1:0] v;
    for (int i = 0; i < ROWS; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  // One clock cycle: drive the array bottom edge, sample at the falling edge, then advance the model.
  task automatic step();
    int s;
    bit exp_ar, acc, drain_exit;
    logic [ROWS*COLS-1:0] exp_mode;
    logic [COLS-1:0]      exp_up;
    s = cyc % RING;
    sa_en_down = drv_en[s];
    for (int j = 0; j < COLS; j++) sa_data_down[j*DW +: DW] = drv_d[s][j];
    @(negedge clk);
    exp_ar = (ph == P_STREAM) && (m_acc < m_k);
    acc    = a_valid && exp_ar;
    if (acc) begin
      for (int i = 0; i < ROWS; i++) begin
        exp_left_en[(cyc+i)%RING][i] = 1'b1;
        exp_left_d[(cyc+i)%RING][i]  = a_data[i*DW +: DW];
      end
      sched_result(cyc + ROWS, rand_row());
    end
    exp_mode = (ph == P_LOAD) ? '1 : '0;
    exp_up   = (ph == P_LOAD && w_valid) ? '1 : '0;
    check("busy", busy, ph inside {P_LOAD, P_STREAM, P_DRAIN});
    check("done", done, ph == P_DONE);
    check("w_ready", w_ready, ph == P_LOAD);
    check("a_ready", a_ready, exp_ar);
    check("sa_mode", sa_mode, exp_mode);
    check("sa_en_up", sa_en_up, exp_up);
    if (exp_up != '0) check("sa_data_up", sa_data_up, w_data);
    check("sa_en_left", sa_en_left, exp_left_en[s]);
    for (int i = 0; i < ROWS; i++)
      if (exp_left_en[s][i]) check("sa_data_left", sa_data_left[i*DW +: DW], exp_left_d[s][i]);
    check("r_valid", r_valid, exp_r[s]);
    if (exp_r[s]) check("r_data", r_data, exp_rd[s]);
    obs_rv  += int'(r_valid);
    obs_acc += int'(a_valid && a_ready);
    obs_up  += int'(sa_en_up != '0);
    obs_ar  += int'(a_ready);
    if (done) begin obs_done++; rv_at_done = obs_rv; end
    drain_exit = (ph == P_DRAIN) && (m_res == m_k);
    if ((ph == P_STREAM || ph == P_DRAIN) && exp_r[s] && m_res < m_k) m_res++;
    case (ph)
      P_IDLE:   if (start) begin ph = P_LOAD; m_k = int'(k_len); m_rows = 0; m_acc = 0; m_res = 0; end
      P_LOAD:   if (w_valid) begin m_rows++; if (m_rows == ROWS) ph = (m_k != 0) ? P_STREAM : P_DONE; end
      P_STREAM: if (acc) begin m_acc++; if (m_acc == m_k) ph = P_DRAIN; end
      P_DRAIN:  if (drain_exit) ph = P_DONE;
      default:  ph = P_IDLE;
    endcase
    exp_left_en[s] = '0; exp_r[s] = 1'b0; drv_en[s] = '0;
    for (int j = 0; j < COLS; j++) drv_d[s][j] = '0;
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
  endtask

  task automatic run_idle(input int n);
    w_valid = 1'b0; a_valid = 1'b0;
    for (int n_i = 0; n_i < n; n_i++) step();
  endtask

  task automatic begin_job(input int k);
    start = 1'b1; k_len = KW'(k);
    obs_done = 0; obs_rv = 0; obs_acc = 0; obs_up = 0; obs_ar = 0; rv_at_done = -1;
    step();
  endtask

  task automatic load_rows(input bit gappy);
    int guard = 0;
    while (ph == P_LOAD && guard < 200) begin
      w_valid = gappy ? ($urandom_range(0, 3) != 0) : 1'b1;
      w_data  = rand_row();
      step();
      guard++;
    end
    w_valid = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    int guard = 0;
    while (ph != P_IDLE && guard < 400) begin
      a_valid = (ph == P_STREAM) ? ($urandom_range(0, 2) != 0) : 1'b0;
      a_data  = rand_vec();
      step();
      guard++;
    end
    a_valid = 1'b0;
    check({tag, "_completes"}, ph == P_IDLE, 1'b1);
    check({tag, "_done_pulses"}, obs_done, 1);
  endtask

  task automatic reset_and_check(input string tag);
    rst_n = 1'b0; start = 1'b0; w_valid = 1'b0; a_valid = 1'b0; sa_en_down = '0; sa_data_down = '0;
    #1;
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_w_ready"}, w_ready, 1'b0);
    check({tag, "_a_ready"}, a_ready, 1'b0);
    check({tag, "_r_valid"}, r_valid, 1'b0);
    check({tag, "_sa_mode"}, sa_mode, '0);
    check({tag, "_sa_en_up"}, sa_en_up, '0);
    check({tag, "_sa_en_left"}, sa_en_left, '0);
    check({tag, "_sa_data_up"}, sa_data_up, '0);
    check({tag, "_sa_data_left"}, sa_data_left, '0);
    check({tag, "_r_data"}, r_data, '0);
    clear_model();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  initial begin
    int t0;
    logic [COLS*DW-1:0] drow;

    clear_model();
    reset_and_check("reset");

    // Weight load with back-to-back rows, then a single vector whose row i holds i+1.
    begin_job(3);
    load_rows(1'b0);
    check("load_en_up_cycles", obs_up, ROWS);
    check("load_then_stream", ph == P_STREAM, 1'b1);
    a_valid = 1'b1;
    for (int i = 0; i < ROWS; i++) a_data[i*DW +: DW] = DW'(i + 1);
    step();
    a_valid = 1'b0;
    start = 1'b1; k_len = KW'(7);
    step();
    run_idle(ROWS);
    finish_job("skew_job");
    check("skew_job_acceptances", obs_acc, 3);

    // Deskew in IDLE: column j carries 100+j at t0+j.
    t0 = cyc + 2;
    for (int j = 0; j < COLS; j++) begin
      drv_en[(t0+j)%RING][j] = 1'b1;
      drv_d[(t0+j)%RING][j]  = DW'(100 + j);
      drow[j*DW +: DW]       = DW'(100 + j);
    end
    exp_r[(t0+COLS-1)%RING]  = 1'b1;
    exp_rd[(t0+COLS-1)%RING] = drow;
    obs_rv = 0;
    run_idle(12);
    check("deskew_rvalid_count", obs_rv, 1);

    // Zero-length job: done right after the last weight row, a_ready never raised.
    begin_job(0);
    load_rows(1'b0);
    run_idle(1);
    check("k0_done", obs_done, 1);
    check("k0_a_ready_never", obs_ar, 0);
    run_idle(2);

    // Alternating a_valid with k=4. A start during the job must be ignored.
    begin_job(4);
    start = 1'b1; k_len = KW'(2);
    load_rows(1'b0);
    for (int n = 0; n < 40 && ph == P_STREAM; n++) begin
      a_valid = (n % 2 == 0);
      a_data  = rand_vec();
      if (n == 3) begin start = 1'b1; k_len = KW'(9); end
      step();
    end
    finish_job("toggle_job");
    check("toggle_acceptances", obs_acc, 4);
    check("toggle_done_after_4th_r", rv_at_done, 4);

    // Random jobs with gappy handshakes on both sides.
    for (int job = 0; job < 5; job++) begin
      begin_job($urandom_range(1, 6));
      load_rows(1'b1);
      finish_job("rand_job");
      run_idle($urandom_range(0, 3));
    end

    // Reset partway through streaming abandons the job. The next start reloads all rows.
    begin_job(5);
    load_rows(1'b0);
    for (int n = 0; n < 20 && m_acc < 2; n++) begin
      a_valid = 1'b1; a_data = rand_vec();
      step();
    end
    a_valid = 1'b1;
    reset_and_check("midreset");
    obs_done = 0;
    run_idle(20);
    check("midreset_no_done", obs_done, 0);
    begin_job(2);
    load_rows(1'b1);
    check("restart_rows_from_zero", obs_up, ROWS);
    finish_job("restart_job");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
